// File: rtl/frame_flush_controller_if.sv
// Avalon-style SDRAM write-master bus used by the frame flush controller.
// The master drives the request/data/address; the slave stalls with waitrequest.
interface frame_flush_controller_if #(
   parameter int SD_ADDR_W = 26,
   parameter int SD_DATA_W = 32
);
   logic                 SD_write;
   logic [SD_DATA_W-1:0] SD_wdata;
   logic [SD_ADDR_W-1:0] SD_address;
   logic                 waitrequest;

   modport master (
      output SD_write, SD_wdata, SD_address,
      input  waitrequest
   );

   modport slave (
      input  SD_write, SD_wdata, SD_address,
      output waitrequest
   );
endinterface

// File: rtl/frame_flush_controller.sv
// Blend-side frame-buffer port plus a flush engine that streams the finished frame,
// followed by black padding words, to SDRAM; returns to blend mode after every frame.
module frame_flush_controller #(
   parameter int CH_W       = 8,
   parameter int ADDR_W     = 17,
   parameter int SRC_PIXELS = 76800,
   parameter int DST_WORDS  = 307200,
   parameter int SD_ADDR_W  = 26,
   parameter int SD_DATA_W  = 32,
   parameter int SD_BASE    = 0,
   parameter int SD_STEP    = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [CH_W-1:0]      write_r,
   input  logic [CH_W-1:0]      write_g,
   input  logic [CH_W-1:0]      write_b,
   input  logic                 write,
   input  logic                 read,
   input  logic [ADDR_W-1:0]    Pixel_Number,
   input  logic                 frame_ready,
   output logic [CH_W-1:0]      read_r,
   output logic [CH_W-1:0]      read_g,
   output logic [CH_W-1:0]      read_b,
   input  logic [3*CH_W-1:0]    M9_rdata,
   output logic [3*CH_W-1:0]    M9_wdata,
   output logic [ADDR_W-1:0]    write_address,
   output logic [ADDR_W-1:0]    read_address,
   output logic                 M9_write,
   frame_flush_controller_if.master sd,
   output logic                 busy,
   output logic                 frame_done
);

   localparam int IDX_W = $clog2(DST_WORDS + 1);
   localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(DST_WORDS);
   localparam logic [IDX_W-1:0]     SRC_END  = IDX_W'(SRC_PIXELS);
   localparam logic [SD_ADDR_W-1:0] BASE_A   = SD_ADDR_W'(SD_BASE);
   localparam logic [SD_ADDR_W-1:0] STEP_A   = SD_ADDR_W'(SD_STEP);

   typedef enum logic [2:0] {BLEND, FETCH, CAPTURE, WRITE, DONE} state_t;

   state_t           state;
   logic [IDX_W-1:0] idx;
   logic [IDX_W-1:0] idx_nxt;

   function automatic logic [SD_DATA_W-1:0] zext_pixel(input logic [3*CH_W-1:0] px);
      return SD_DATA_W'(px);
   endfunction

   assign idx_nxt = idx + IDX_W'(1);

   assign read_r = M9_rdata[3*CH_W-1:2*CH_W];
   assign read_g = M9_rdata[2*CH_W-1:CH_W];
   assign read_b = M9_rdata[CH_W-1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= BLEND;
         idx           <= '0;
         M9_write      <= 1'b0;
         M9_wdata      <= '0;
         write_address <= '0;
         read_address  <= '0;
         sd.SD_write   <= 1'b0;
         sd.SD_wdata   <= '0;
         sd.SD_address <= BASE_A;
         busy          <= 1'b0;
         frame_done    <= 1'b0;
      end else begin
         M9_write   <= 1'b0;
         frame_done <= 1'b0;
         case (state)
            BLEND: begin
               // A pending write defers the flush; frame_ready is a level so it is retried.
               if (write) begin
                  M9_write      <= 1'b1;
                  write_address <= Pixel_Number;
                  M9_wdata      <= {write_r, write_g, write_b};
               end else if (frame_ready) begin
                  state        <= FETCH;
                  idx          <= '0;
                  read_address <= '0;
                  busy         <= 1'b1;
               end else if (read) begin
                  read_address <= Pixel_Number;
               end
            end
            FETCH: state <= CAPTURE;
            CAPTURE: begin
               sd.SD_wdata <= zext_pixel(M9_rdata);
               sd.SD_write <= 1'b1;
               state       <= WRITE;
            end
            WRITE: begin
               // Request, data and address stay frozen until the slave accepts the word.
               if (!sd.waitrequest) begin
                  idx           <= idx_nxt;
                  sd.SD_address <= sd.SD_address + STEP_A;
                  if (idx_nxt == LAST_IDX) begin
                     state       <= DONE;
                     sd.SD_write <= 1'b0;
                     frame_done  <= 1'b1;
                  end else if (idx_nxt < SRC_END) begin
                     state        <= FETCH;
                     read_address <= ADDR_W'(idx_nxt);
                     sd.SD_write  <= 1'b0;
                  end else begin
                     sd.SD_wdata <= '0;
                  end
               end
            end
            DONE: begin
               idx           <= '0;
               sd.SD_address <= BASE_A;
               busy          <= 1'b0;
               state         <= BLEND;
            end
            default: state <= BLEND;
         endcase
      end
   end

endmodule

// File: tb/tb_frame_flush_controller.sv
// Directed bench for frame_flush_controller with a small frame (4 source pixels, 6 SDRAM words).
module tb_frame_flush_controller;
   localparam int CH_W      = 8;
   localparam int ADDR_W    = 17;
   localparam int SRC       = 4;
   localparam int DST       = 6;
   localparam int SD_ADDR_W = 26;
   localparam int SD_DATA_W = 32;
   localparam int SD_BASE   = 32'h100;
   localparam int SD_STEP   = 4;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [CH_W-1:0]      write_r, write_g, write_b;
   logic                 write, read;
   logic [ADDR_W-1:0]    Pixel_Number;
   logic                 frame_ready;
   logic [CH_W-1:0]      read_r, read_g, read_b;
   logic [3*CH_W-1:0]    M9_rdata;
   logic [3*CH_W-1:0]    M9_wdata;
   logic [ADDR_W-1:0]    write_address, read_address;
   logic                 M9_write;
   logic                 busy, frame_done;

   logic [3*CH_W-1:0]    mem [16];

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0] lg_addr [$];
   logic [31:0] lg_data [$];
   bit          lg_acc  [$];

   always #5 clk = ~clk;

   frame_flush_controller_if #(.SD_ADDR_W(SD_ADDR_W), .SD_DATA_W(SD_DATA_W)) sd_bus ();

   frame_flush_controller #(
      .CH_W(CH_W), .ADDR_W(ADDR_W), .SRC_PIXELS(SRC), .DST_WORDS(DST),
      .SD_ADDR_W(SD_ADDR_W), .SD_DATA_W(SD_DATA_W), .SD_BASE(SD_BASE), .SD_STEP(SD_STEP)
   ) dut (
      .clk(clk), .rst(rst),
      .write_r(write_r), .write_g(write_g), .write_b(write_b),
      .write(write), .read(read), .Pixel_Number(Pixel_Number),
      .frame_ready(frame_ready),
      .read_r(read_r), .read_g(read_g), .read_b(read_b),
      .M9_rdata(M9_rdata), .M9_wdata(M9_wdata),
      .write_address(write_address), .read_address(read_address),
      .M9_write(M9_write), .sd(sd_bus),
      .busy(busy), .frame_done(frame_done)
   );

   // Synchronous-read frame buffer model
   always @(posedge clk) begin
      if (M9_write) mem[write_address[3:0]] <= M9_wdata;
      M9_rdata <= mem[read_address[3:0]];
   end

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic blend_write(input int pix, input logic [7:0] r, input logic [7:0] g,
                              input logic [7:0] b);
      @(negedge clk);
      write = 1'b1; Pixel_Number = ADDR_W'(pix);
      write_r = r; write_g = g; write_b = b;
   endtask

   // Raises frame_ready (optionally together with a write of pixel 3) and tracks the flush.
   task automatic run_flush(input int stall_addr, input int stall_n, input bit defer,
                            output int cycles, output int stalls);
      bit done;
      lg_addr.delete(); lg_data.delete(); lg_acc.delete();
      @(negedge clk);
      frame_ready = 1'b1;
      if (defer) begin
         write = 1'b1; Pixel_Number = 3; write_r = 8'h01; write_g = 8'h02; write_b = 8'h03;
      end
      cycles = 0; stalls = 0; done = 1'b0;
      while (!done && cycles < 200) begin
         @(negedge clk);
         cycles++;
         if (defer && cycles == 1) begin
            check_val("defer_busy_low", busy, 0);
            check_val("defer_m9_write", M9_write, 1);
            check_val("defer_waddr", write_address, 3);
            write = 1'b0;
         end
         if (cycles == (defer ? 2 : 1)) check_val("busy_rise", busy, 1);
         if (busy) frame_ready = 1'b0;
         if (frame_done) done = 1'b1;
         else begin
            sd_bus.waitrequest = sd_bus.SD_write && (32'(sd_bus.SD_address) == stall_addr)
                                 && (stalls < stall_n);
            if (sd_bus.SD_write) begin
               lg_addr.push_back(32'(sd_bus.SD_address));
               lg_data.push_back(sd_bus.SD_wdata);
               lg_acc.push_back(!sd_bus.waitrequest);
               if (sd_bus.waitrequest) stalls++;
            end
         end
      end
      sd_bus.waitrequest = 1'b0;
      frame_ready = 1'b0;
      check_val("frame_done_seen", done, 1);
   endtask

   task automatic check_words(input logic [31:0] p0, input logic [31:0] p1,
                              input logic [31:0] p2, input logic [31:0] p3);
      logic [31:0] px [4];
      int k;
      px[0] = p0; px[1] = p1; px[2] = p2; px[3] = p3;
      k = 0;
      for (int i = 0; i < lg_addr.size(); i++) begin
         if (lg_acc[i]) begin
            check_val($sformatf("word%0d_addr", k), lg_addr[i], SD_BASE + SD_STEP * k);
            check_val($sformatf("word%0d_data", k), lg_data[i], (k < SRC) ? px[k] : 32'h0);
            k++;
         end
      end
      check_val("word_count", k, DST);
   endtask

   task automatic check_idle(input string tag);
      @(negedge clk);
      check_val({tag, "_busy"}, busy, 0);
      check_val({tag, "_done"}, frame_done, 0);
      check_val({tag, "_sdaddr"}, sd_bus.SD_address, SD_BASE);
      check_val({tag, "_sdwrite"}, sd_bus.SD_write, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int cyc, stl, n104, bound, fd_seen;
      rst = 1'b1; write = 1'b0; read = 1'b0; frame_ready = 1'b0; Pixel_Number = '0;
      write_r = '0; write_g = '0; write_b = '0; sd_bus.waitrequest = 1'b0;
      repeat (3) @(negedge clk);
      check_val("rst_busy", busy, 0);
      check_val("rst_frame_done", frame_done, 0);
      check_val("rst_m9_write", M9_write, 0);
      check_val("rst_m9_wdata", M9_wdata, 0);
      check_val("rst_waddr", write_address, 0);
      check_val("rst_raddr", read_address, 0);
      check_val("rst_sd_write", sd_bus.SD_write, 0);
      check_val("rst_sd_wdata", sd_bus.SD_wdata, 0);
      check_val("rst_sd_addr", sd_bus.SD_address, SD_BASE);
      rst = 1'b0;

      // Blend write then read back pixel 2
      blend_write(2, 8'h11, 8'h22, 8'h33);
      @(negedge clk);
      check_val("bw_m9_write", M9_write, 1);
      check_val("bw_waddr", write_address, 2);
      check_val("bw_wdata", M9_wdata, 24'h112233);
      write = 1'b0; read = 1'b1; Pixel_Number = 2;
      @(negedge clk);
      check_val("br_raddr", read_address, 2);
      check_val("br_m9_write_low", M9_write, 0);
      read = 1'b0;
      @(negedge clk);
      check_val("br_read_r", read_r, 8'h11);
      check_val("br_read_g", read_g, 8'h22);
      check_val("br_read_b", read_b, 8'h33);

      // Write and read together: write wins, read_address untouched
      blend_write(1, 8'h44, 8'h55, 8'h66);
      read = 1'b1;
      @(negedge clk);
      check_val("wr_prio_write", M9_write, 1);
      check_val("wr_prio_waddr", write_address, 1);
      check_val("wr_prio_wdata", M9_wdata, 24'h445566);
      check_val("wr_prio_raddr", read_address, 2);
      read = 1'b0;

      // Preload frame with 0xA0+i
      for (int i = 0; i < SRC; i++) blend_write(i, 8'h00, 8'h00, 8'(8'hA0 + i));
      @(negedge clk);
      write = 1'b0;

      // Unstalled flush
      run_flush(-1, 0, 1'b0, cyc, stl);
      check_val("flush1_latency", cyc, 15);
      check_words(32'hA0, 32'hA1, 32'hA2, 32'hA3);
      check_idle("flush1_after");

      // Second frame with word 1 stalled for 5 cycles
      run_flush(SD_BASE + 4, 5, 1'b0, cyc, stl);
      check_val("flush2_stalls", stl, 5);
      check_val("flush2_latency", cyc, 20);
      check_words(32'hA0, 32'hA1, 32'hA2, 32'hA3);
      check_val("flush2_entries", lg_addr.size(), 11);
      n104 = 0;
      for (int i = 0; i < lg_addr.size(); i++) begin
         if (lg_addr[i] == SD_BASE + 4) begin
            n104++;
            check_val($sformatf("stall_data%0d", n104), lg_data[i], 32'hA1);
         end
      end
      check_val("stall_hold_cycles", n104, 6);
      check_idle("flush2_after");

      // frame_ready together with a write: write lands, flush one cycle later
      run_flush(-1, 0, 1'b1, cyc, stl);
      check_val("flush3_latency", cyc, 16);
      check_words(32'hA0, 32'hA1, 32'hA2, 32'h010203);
      check_idle("flush3_after");

      // Reset while padding words are going out
      @(negedge clk);
      frame_ready = 1'b1;
      bound = 0;
      while (!(sd_bus.SD_write && sd_bus.SD_wdata == 0) && bound < 50) begin
         @(negedge clk);
         if (busy) frame_ready = 1'b0;
         bound++;
      end
      check_val("pad_reached", bound < 50, 1);
      frame_ready = 1'b0;
      rst = 1'b1;
      #1;
      check_val("midrst_sd_write", sd_bus.SD_write, 0);
      check_val("midrst_sd_addr", sd_bus.SD_address, SD_BASE);
      check_val("midrst_sd_wdata", sd_bus.SD_wdata, 0);
      check_val("midrst_busy", busy, 0);
      check_val("midrst_raddr", read_address, 0);
      check_val("midrst_m9_wdata", M9_wdata, 0);
      @(negedge clk);
      rst = 1'b0;
      fd_seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (frame_done || busy) fd_seen++;
      end
      check_val("midrst_no_done", fd_seen, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
